// File: rtl/aes_pkg.sv
// Shared constants, state encoding and byte helpers for the AES-128 key schedule.
// The S-box table is stored with entry 0x00 in the most significant byte.
package aes_pkg;

   localparam int KW = 128;
   localparam int NR = 10;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic {
      IDLE,
      EXPAND
   } state_t;

   // GF(2^8) multiply-by-two, used to step the round constant
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule bus: start/key request from the controller, round keys back to the datapath.
// master drives the request side, slave is the key-expansion block.
interface aes_key_expand_if;
   import aes_pkg::*;

   logic          start;
   logic [KW-1:0] key_in;
   logic          busy;
   logic          rk_valid;
   logic [3:0]    rk_idx;
   logic [KW-1:0] rk_out;
   logic          done;

   modport master (
      output start, key_in,
      input  busy, rk_valid, rk_idx, rk_out, done
   );

   modport slave (
      input  start, key_in,
      output busy, rk_valid, rk_idx, rk_out, done
   );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational; one table lookup per byte lane.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // Entry 0x00 sits at the top of the table, so the lane offset uses the inverted byte
   assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

module aes_sub_word (
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      aes_sbox u_sbox (
         .in_byte  (word_in[8*i +: 8]),
         .out_byte (word_out[8*i +: 8])
      );
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: presents round keys 0..10 on consecutive cycles
// after an accepted start; every output comes straight from a register.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   aes_key_expand_if.slave kx
);

   localparam logic [3:0] LAST_IDX = 4'(NR);

   state_t        state, state_next;
   logic [KW-1:0] rk_q, rk_next, rk_gen;
   logic [7:0]    rcon_q, rcon_next;
   logic [3:0]    idx_q, idx_next;
   logic          busy_q, busy_next;
   logic          valid_q, valid_next;
   logic          done_q, done_next;

   logic [31:0]   rot_w3, sub_w3, t_word;
   logic [31:0]   w0_n, w1_n, w2_n, w3_n;

   // Next round key derived from the key currently on the output
   assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

   aes_sub_word u_sub_word (
      .word_in  (rot_w3),
      .word_out (sub_w3)
   );

   assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
   assign w0_n   = rk_q[127:96] ^ t_word;
   assign w1_n   = rk_q[95:64]  ^ w0_n;
   assign w2_n   = rk_q[63:32]  ^ w1_n;
   assign w3_n   = rk_q[31:0]   ^ w2_n;
   assign rk_gen = {w0_n, w1_n, w2_n, w3_n};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rk_q    <= '0;
         rcon_q  <= RCON_INIT;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_next;
         rk_q    <= rk_next;
         rcon_q  <= rcon_next;
         idx_q   <= idx_next;
         busy_q  <= busy_next;
         valid_q <= valid_next;
         done_q  <= done_next;
      end
   end

   // start is only looked at in IDLE, so pulses during expansion (even on done) are dropped
   always_comb begin
      state_next = state;
      rk_next    = rk_q;
      rcon_next  = rcon_q;
      idx_next   = idx_q;
      busy_next  = busy_q;
      valid_next = valid_q;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (kx.start) begin
               state_next = EXPAND;
               rk_next    = kx.key_in;
               rcon_next  = RCON_INIT;
               idx_next   = 4'd0;
               busy_next  = 1'b1;
               valid_next = 1'b1;
            end
         end
         EXPAND: begin
            if (idx_q == LAST_IDX) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               valid_next = 1'b0;
            end else begin
               rk_next   = rk_gen;
               rcon_next = xtime(rcon_q);
               idx_next  = idx_q + 4'd1;
               done_next = (idx_q == LAST_IDX - 4'd1);
            end
         end
      endcase
   end

   assign kx.busy     = busy_q;
   assign kx.rk_valid = valid_q;
   assign kx.rk_idx   = idx_q;
   assign kx.rk_out   = rk_q;
   assign kx.done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key vectors.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_aes_key_expand;

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic clk = 1'b0;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   logic [127:0] rk_seen [0:10];
   int           valid_cnt;
   int           done_cnt;
   bit           reset_hit;

   always #5 clk = ~clk;

   aes_key_expand_if kx ();

   aes_key_expand dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kx    (kx)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pulse start for one edge with the given key; returns with round 0 visible
   task automatic applyStimulus(input logic [127:0] key);
      kx.key_in = key;
      kx.start  = 1'b1;
      @(posedge clk);
      #1;
      kx.start  = 1'b0;
   endtask

   // Follows one expansion until busy drops (or reset is forced), recording every valid key
   task automatic collectRun(input string tag, input int pulse_idx, input bit pulse_done,
                             input bit scramble, input int reset_idx);
      int cycles   = 0;
      bit finished = 1'b0;
      valid_cnt = 0;
      done_cnt  = 0;
      reset_hit = 1'b0;
      for (int i = 0; i <= 10; i++) rk_seen[i] = 'x;
      checkOutput({tag, "_first_idx"}, {123'd0, kx.rk_valid, kx.rk_idx}, {123'd0, 1'b1, 4'd0});
      while (!finished && cycles < 20) begin
         if (kx.rk_valid) begin
            if (kx.rk_idx <= 4'd10) rk_seen[kx.rk_idx] = kx.rk_out;
            valid_cnt++;
         end
         if (kx.done) begin
            done_cnt++;
            checkOutput({tag, "_done_idx"}, 128'(kx.rk_idx), 128'd10);
         end
         if (kx.rk_valid && reset_idx >= 0 && int'(kx.rk_idx) == reset_idx) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput({tag, "_rst_busy"},  128'(kx.busy),     128'd0);
            checkOutput({tag, "_rst_valid"}, 128'(kx.rk_valid), 128'd0);
            checkOutput({tag, "_rst_idx"},   128'(kx.rk_idx),   128'd0);
            checkOutput({tag, "_rst_out"},   kx.rk_out,         128'd0);
            checkOutput({tag, "_rst_done"},  128'(kx.done),     128'd0);
            reset_hit = 1'b1;
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk);
            #1;
            finished = 1'b1;
         end else if (!kx.busy) begin
            finished = 1'b1;
         end else begin
            kx.start = (kx.rk_valid && int'(kx.rk_idx) == pulse_idx) || (pulse_done && kx.done);
            if (scramble) kx.key_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            kx.start = 1'b0;
            cycles++;
         end
      end
      if (!reset_hit) checkOutput({tag, "_end_busy"}, 128'(kx.busy), 128'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      kx.start  = 1'b0;
      kx.key_in = '0;
      #12;
      checkOutput("reset_busy",  128'(kx.busy),     128'd0);
      checkOutput("reset_valid", 128'(kx.rk_valid), 128'd0);
      checkOutput("reset_idx",   128'(kx.rk_idx),   128'd0);
      checkOutput("reset_out",   kx.rk_out,         128'd0);
      checkOutput("reset_done",  128'(kx.done),     128'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 A.1 key
      applyStimulus(KEY_A1);
      collectRun("a1", -1, 1'b0, 1'b0, -1);
      checkOutput("a1_r0",     rk_seen[0],       KEY_A1);
      checkOutput("a1_r1",     rk_seen[1],       A1_R1);
      checkOutput("a1_r10",    rk_seen[10],      A1_R10);
      checkOutput("a1_nvalid", 128'(valid_cnt),  128'd11);
      checkOutput("a1_ndone",  128'(done_cnt),   128'd1);
      checkOutput("a1_hold",   kx.rk_out,        A1_R10);
      @(posedge clk);
      #1;
      checkOutput("a1_idle_valid", 128'(kx.rk_valid), 128'd0);
      checkOutput("a1_idle_hold",  kx.rk_out,         A1_R10);

      // All-zero key
      applyStimulus(128'd0);
      collectRun("zero", -1, 1'b0, 1'b0, -1);
      checkOutput("zero_r0",  rk_seen[0],  128'd0);
      checkOutput("zero_r1",  rk_seen[1],  ZERO_R1);
      checkOutput("zero_r10", rk_seen[10], ZERO_R10);

      // start pulses at idx 4 and on the done cycle must be ignored
      applyStimulus(KEY_A1);
      collectRun("ign", 4, 1'b1, 1'b0, -1);
      checkOutput("ign_r1",     rk_seen[1],      A1_R1);
      checkOutput("ign_r10",    rk_seen[10],     A1_R10);
      checkOutput("ign_nvalid", 128'(valid_cnt), 128'd11);
      checkOutput("ign_ndone",  128'(done_cnt),  128'd1);

      // Back-to-back: second start on the first idle cycle
      applyStimulus(KEY_A1);
      collectRun("b2b_a", -1, 1'b0, 1'b0, -1);
      checkOutput("b2b_a_r10", rk_seen[10], A1_R10);
      applyStimulus(128'd0);
      collectRun("b2b_z", -1, 1'b0, 1'b0, -1);
      checkOutput("b2b_z_r0",     rk_seen[0],      128'd0);
      checkOutput("b2b_z_r1",     rk_seen[1],      ZERO_R1);
      checkOutput("b2b_z_r10",    rk_seen[10],     ZERO_R10);
      checkOutput("b2b_z_nvalid", 128'(valid_cnt), 128'd11);

      // Reset in the middle of an expansion, then a fresh run
      applyStimulus(KEY_A1);
      collectRun("rst", -1, 1'b0, 1'b0, 6);
      checkOutput("rst_nvalid", 128'(valid_cnt), 128'd7);
      checkOutput("rst_ndone",  128'(done_cnt),  128'd0);
      checkOutput("rst_r1",     rk_seen[1],      A1_R1);
      checkOutput("rst_idle_valid", 128'(kx.rk_valid), 128'd0);
      applyStimulus(128'd0);
      collectRun("post", -1, 1'b0, 1'b0, -1);
      checkOutput("post_r1",     rk_seen[1],      ZERO_R1);
      checkOutput("post_r10",    rk_seen[10],     ZERO_R10);
      checkOutput("post_nvalid", 128'(valid_cnt), 128'd11);
      checkOutput("post_ndone",  128'(done_cnt),  128'd1);

      // key_in scrambled every cycle after the accepted start
      applyStimulus(KEY_A1);
      collectRun("scr", -1, 1'b0, 1'b1, -1);
      checkOutput("scr_r0",  rk_seen[0],  KEY_A1);
      checkOutput("scr_r1",  rk_seen[1],  A1_R1);
      checkOutput("scr_r10", rk_seen[10], A1_R10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
